// File: rtl/lsab_pkg.sv
// Shared constants and types for the four-channel LSAB "cr" buffer.
package lsab_pkg;

  localparam int LSAB_DEPTH_LOG2 = 6;
  localparam int LSAB_WIDTH      = 32;
  localparam int LSAB_NCHAN      = 4;

  typedef logic [1:0] lsab_chan_t;

  typedef struct packed {
    logic                  int_marker;
    logic [LSAB_WIDTH-1:0] data;
  } lsab_entry_t;

endpackage

// File: rtl/lsab_cr_chan_ctl.sv
// Per-channel pointer/flag controller: full/empty, interrupt stop flag, registered EMPTY/STOP.
// Optional sticky overflow flag when LSAB_CR_OVERFLOW_FLAG_EN is defined.
module lsab_cr_chan_ctl
  import lsab_pkg::*;
#(
  parameter int DEPTH_LOG2 = LSAB_DEPTH_LOG2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_i,
  input  logic                  rd_i,
  input  logic                  hold_i,
  output logic                  wr_ok_o,
  output logic                  rd_ok_o,
  output logic [DEPTH_LOG2-1:0] wptr_o,
  output logic [DEPTH_LOG2-1:0] rptr_o,
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
  output logic                  ovf_o,
`endif
  output logic                  empty_o,
  output logic                  stop_o
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic                  stop_q, stop_d;
  logic                  empty_q, stop_out_q;
  logic                  empty, full, wr_ok, rd_ok, empty_nxt;

  // Emptiness and fullness are both judged on the pointers before this edge.
  always_comb begin
    empty     = (rptr_q == wptr_q);
    full      = ((wptr_q + PTR_ONE) == rptr_q);
    wr_ok     = wr_i & ~full;
    rd_ok     = rd_i & ~empty;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    stop_d    = stop_q;
    if (wr_ok) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (rd_ok) begin
      stop_d = hold_i;
      if (!hold_i) begin
        rptr_d = rptr_q + PTR_ONE;
      end
    end
    empty_nxt = (rptr_d == wptr_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      stop_q     <= 1'b0;
      empty_q    <= 1'b1;
      stop_out_q <= 1'b1;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      stop_q     <= stop_d;
      empty_q    <= empty_nxt;
      stop_out_q <= empty_nxt | stop_d;
    end
  end

`ifdef LSAB_CR_OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else if (wr_i && full) begin
      ovf_q <= 1'b1;
    end else if (rd_ok && empty_nxt) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_o = ovf_q;
`endif

  assign wr_ok_o = wr_ok;
  assign rd_ok_o = rd_ok;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign empty_o = empty_q;
  assign stop_o  = stop_out_q;

endmodule

// File: rtl/lsab_cr_buffer.sv
// Four-channel LSAB buffer, clock-coherent variant: per-channel RAMs, shared read port, 2-edge read latency.
// Define LSAB_CR_OVERFLOW_FLAG_EN to add the sticky OVERFLOW[3:0] output.
module lsab_cr_buffer
  import lsab_pkg::*;
#(
  parameter int DEPTH_LOG2 = LSAB_DEPTH_LOG2,
  parameter int WIDTH      = LSAB_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             READ,
  input  lsab_chan_t       READ_FIFO,
  input  logic             WRITE0,
  input  logic             WRITE1,
  input  logic             WRITE2,
  input  logic             WRITE3,
  input  lsab_chan_t       WRITE_FIFO,
  input  logic [WIDTH-1:0] IN_0,
  input  logic [WIDTH-1:0] IN_1,
  input  logic [WIDTH-1:0] IN_2,
  input  logic [WIDTH-1:0] IN_3,
  input  logic             INT_IN_0,
  input  logic             INT_IN_1,
  input  logic             INT_IN_2,
  input  logic             INT_IN_3,
  input  logic             CAREOF_INT_0,
  input  logic             CAREOF_INT_1,
  input  logic             CAREOF_INT_2,
  input  logic             CAREOF_INT_3,
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
  output logic [3:0]       OVERFLOW,
`endif
  output logic [WIDTH-1:0] OUT,
  output logic             EMPTY_0,
  output logic             EMPTY_1,
  output logic             EMPTY_2,
  output logic             EMPTY_3,
  output logic             STOP_0,
  output logic             STOP_1,
  output logic             STOP_2,
  output logic             STOP_3
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH:0]          ram_q [LSAB_NCHAN][DEPTH];
  logic [WIDTH-1:0]        in_data [LSAB_NCHAN];
  logic [DEPTH_LOG2-1:0]   wptr [LSAB_NCHAN];
  logic [DEPTH_LOG2-1:0]   rptr [LSAB_NCHAN];
  logic [LSAB_NCHAN-1:0]   wr_en, int_in, careof;
  logic [LSAB_NCHAN-1:0]   wr_req, rd_req, hold, wr_ok, rd_ok, empty_st, stop_st;
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
  logic [LSAB_NCHAN-1:0]   ovf;
`endif

  logic                  vld_p0, vld_p1;
  lsab_chan_t            ch_p0;
  logic [DEPTH_LOG2-1:0] addr_p0;
  logic [WIDTH-1:0]      data_p1;
  logic [WIDTH-1:0]      out_q;

  assign in_data[0] = IN_0;
  assign in_data[1] = IN_1;
  assign in_data[2] = IN_2;
  assign in_data[3] = IN_3;
  assign wr_en      = {WRITE3, WRITE2, WRITE1, WRITE0};
  assign int_in     = {INT_IN_3, INT_IN_2, INT_IN_1, INT_IN_0};
  assign careof     = {CAREOF_INT_3, CAREOF_INT_2, CAREOF_INT_1, CAREOF_INT_0};

  for (genvar n = 0; n < LSAB_NCHAN; n++) begin : g_chan
    assign wr_req[n] = wr_en[n] && (WRITE_FIFO == lsab_chan_t'(n));
    assign rd_req[n] = READ && (READ_FIFO == lsab_chan_t'(n));
    // An honoured marker pins the read pointer so the word is re-delivered once.
    assign hold[n]   = ram_q[n][rptr[n]][WIDTH] & careof[n];

    lsab_cr_chan_ctl #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ctl (
      .CLK     (CLK),
      .RST     (RST),
      .wr_i    (wr_req[n]),
      .rd_i    (rd_req[n]),
      .hold_i  (hold[n]),
      .wr_ok_o (wr_ok[n]),
      .rd_ok_o (rd_ok[n]),
      .wptr_o  (wptr[n]),
      .rptr_o  (rptr[n]),
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
      .ovf_o   (ovf[n]),
`endif
      .empty_o (empty_st[n]),
      .stop_o  (stop_st[n])
    );
  end

  // Write port plus marker clear; they never collide because a readable entry is never at wptr.
  always_ff @(posedge CLK) begin
    for (int n = 0; n < LSAB_NCHAN; n++) begin
      if (wr_ok[n]) begin
        ram_q[n][wptr[n]] <= {int_in[n], in_data[n]};
      end
      if (rd_ok[n] && hold[n]) begin
        ram_q[n][rptr[n]][WIDTH] <= 1'b0;
      end
    end
  end

  // Stage p0: capture accepted read address
  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= |rd_ok;
      vld_p1 <= vld_p0;
    end
  end

  always_ff @(posedge CLK) begin
    if (|rd_ok) begin
      ch_p0   <= READ_FIFO;
      addr_p0 <= rptr[READ_FIFO];
    end
    // Stage p1: RAM read register
    if (vld_p0) begin
      data_p1 <= ram_q[ch_p0][addr_p0][WIDTH-1:0];
    end
  end

  // Output register holds its value between reads
  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_q <= '0;
    end else if (vld_p1) begin
      out_q <= data_p1;
    end
  end

  assign OUT     = out_q;
  assign EMPTY_0 = empty_st[0];
  assign EMPTY_1 = empty_st[1];
  assign EMPTY_2 = empty_st[2];
  assign EMPTY_3 = empty_st[3];
  assign STOP_0  = stop_st[0];
  assign STOP_1  = stop_st[1];
  assign STOP_2  = stop_st[2];
  assign STOP_3  = stop_st[3];
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
  assign OVERFLOW = ovf;
`endif

endmodule

// File: tb/tb_lsab_cr_buffer.sv
// Directed bench for lsab_cr_buffer: vector table plus overflow and mid-stream reset sequences.
// Status vectors are packed {x_0, x_1, x_2, x_3}; OVERFLOW checks need LSAB_CR_OVERFLOW_FLAG_EN.
module tb_lsab_cr_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        READ;
  logic [1:0]  READ_FIFO;
  logic        WRITE0, WRITE1, WRITE2, WRITE3;
  logic [1:0]  WRITE_FIFO;
  logic [31:0] IN_0, IN_1, IN_2, IN_3;
  logic        INT_IN_0, INT_IN_1, INT_IN_2, INT_IN_3;
  logic        CAREOF_INT_0, CAREOF_INT_1, CAREOF_INT_2, CAREOF_INT_3;
  logic [31:0] OUT;
  logic        EMPTY_0, EMPTY_1, EMPTY_2, EMPTY_3;
  logic        STOP_0, STOP_1, STOP_2, STOP_3;
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
  logic [3:0]  OVERFLOW;
`endif

  logic [3:0] empty_v, stop_v;
  assign empty_v = {EMPTY_0, EMPTY_1, EMPTY_2, EMPTY_3};
  assign stop_v  = {STOP_0, STOP_1, STOP_2, STOP_3};

  int n_chk  = 0;
  int n_fail = 0;

  lsab_cr_buffer dut (
    .CLK          (CLK),
    .RST          (RST),
    .READ         (READ),
    .READ_FIFO    (READ_FIFO),
    .WRITE0       (WRITE0),
    .WRITE1       (WRITE1),
    .WRITE2       (WRITE2),
    .WRITE3       (WRITE3),
    .WRITE_FIFO   (WRITE_FIFO),
    .IN_0         (IN_0),
    .IN_1         (IN_1),
    .IN_2         (IN_2),
    .IN_3         (IN_3),
    .INT_IN_0     (INT_IN_0),
    .INT_IN_1     (INT_IN_1),
    .INT_IN_2     (INT_IN_2),
    .INT_IN_3     (INT_IN_3),
    .CAREOF_INT_0 (CAREOF_INT_0),
    .CAREOF_INT_1 (CAREOF_INT_1),
    .CAREOF_INT_2 (CAREOF_INT_2),
    .CAREOF_INT_3 (CAREOF_INT_3),
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
    .OVERFLOW     (OVERFLOW),
`endif
    .OUT          (OUT),
    .EMPTY_0      (EMPTY_0),
    .EMPTY_1      (EMPTY_1),
    .EMPTY_2      (EMPTY_2),
    .EMPTY_3      (EMPTY_3),
    .STOP_0       (STOP_0),
    .STOP_1       (STOP_1),
    .STOP_2       (STOP_2),
    .STOP_3       (STOP_3)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rd;
    logic [1:0]  rf;
    logic [3:0]  we;
    logic [1:0]  wf;
    logic [31:0] din;
    logic        im;
    logic [3:0]  care;
    logic [3:0]  e;
    logic [3:0]  s;
    logic [31:0] o;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rd, input logic [1:0] rf, input logic [3:0] we,
                              input logic [1:0] wf, input logic [31:0] din, input logic im,
                              input logic [3:0] care, input logic [3:0] e, input logic [3:0] s,
                              input logic [31:0] o);
    vec_t v;
    v.rd = rd; v.rf = rf; v.we = we; v.wf = wf; v.din = din;
    v.im = im; v.care = care; v.e = e; v.s = s; v.o = o;
    vq.push_back(v);
  endfunction

  // Unselected channels see inverted data so a wrong-channel write shows up.
  task automatic drive(input logic rd, input logic [1:0] rf, input logic [3:0] we,
                       input logic [1:0] wf, input logic [31:0] din, input logic im,
                       input logic [3:0] care);
    READ = rd; READ_FIFO = rf; WRITE_FIFO = wf;
    WRITE0 = we[0]; WRITE1 = we[1]; WRITE2 = we[2]; WRITE3 = we[3];
    IN_0 = (wf == 2'd0) ? din : ~din;
    IN_1 = (wf == 2'd1) ? din : ~din;
    IN_2 = (wf == 2'd2) ? din : ~din;
    IN_3 = (wf == 2'd3) ? din : ~din;
    INT_IN_0 = (wf == 2'd0) ? im : ~im;
    INT_IN_1 = (wf == 2'd1) ? im : ~im;
    INT_IN_2 = (wf == 2'd2) ? im : ~im;
    INT_IN_3 = (wf == 2'd3) ? im : ~im;
    CAREOF_INT_0 = care[0]; CAREOF_INT_1 = care[1];
    CAREOF_INT_2 = care[2]; CAREOF_INT_3 = care[3];
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 4'b0000, 2'd0, 32'h0, 1'b0, 4'b0000);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ovf_exp(input int k);
    return (k < 63) ? 32'(2 + k) : 32'(300 + k - 63);
  endfunction

  initial begin
    int cr_out [12];
    cr_out = '{13, 14, 15, 15, 16, 16, 17, 18, 19, 20, 20, 21};

    // Empty read of channel 0 right after reset
    add(1, 0, 4'b0000, 0, 32'h0, 0, 4'b0000, 4'hF, 4'hF, 32'h0);
    // Datagram to channel 2, marker on word 7 not honoured; all WRITEn high so only WRITE_FIFO selects
    for (int i = 0; i < 8; i++)
      add(0, 0, 4'hF, 2, 32'h0020_0004 + i, (i == 3), 4'b0000, 4'b1101, 4'b1101, 32'h0);
    for (int k = 1; k <= 8; k++)
      add(1, 2, 4'b0000, 0, 32'h0, 0, 4'b0000, (k == 8) ? 4'hF : 4'b1101,
          (k == 8) ? 4'hF : 4'b1101, (k <= 2) ? 32'h0 : 32'h0020_0004 + k - 3);
    add(0, 0, 4'b0000, 0, 32'h0, 0, 4'b0000, 4'hF, 4'hF, 32'h0020_000A);
    add(0, 0, 4'b0000, 0, 32'h0, 0, 4'b0000, 4'hF, 4'hF, 32'h0020_000B);
    // Honoured interrupts on channel 2
    for (int i = 0; i < 9; i++)
      add(0, 0, 4'b0100, 2, 32'(13 + i), (13 + i == 15) || (13 + i == 16) || (13 + i == 20),
          4'b0100, 4'b1101, 4'b1101, 32'h0020_000B);
    for (int k = 1; k <= 12; k++)
      add(1, 2, 4'b0000, 0, 32'h0, 0, 4'b0100, (k == 12) ? 4'hF : 4'b1101,
          (k == 12 || k == 3 || k == 5 || k == 10) ? 4'hF : 4'b1101,
          (k <= 2) ? 32'h0020_000B : 32'(cr_out[k - 3]));
    add(0, 0, 4'b0000, 0, 32'h0, 0, 4'b0100, 4'hF, 4'hF, 32'd20);
    add(0, 0, 4'b0000, 0, 32'h0, 0, 4'b0100, 4'hF, 4'hF, 32'd21);
    // Concurrent read and write on a one-word channel 0
    add(0, 0, 4'b0001, 0, 32'hAAAA_0001, 0, 4'b0000, 4'b0111, 4'b0111, 32'd21);
    add(1, 0, 4'b0001, 0, 32'hAAAA_0002, 0, 4'b0000, 4'b0111, 4'b0111, 32'd21);
    add(1, 0, 4'b0000, 0, 32'h0, 0, 4'b0000, 4'hF, 4'hF, 32'd21);
    add(0, 0, 4'b0000, 0, 32'h0, 0, 4'b0000, 4'hF, 4'hF, 32'hAAAA_0001);
    add(0, 0, 4'b0000, 0, 32'h0, 0, 4'b0000, 4'hF, 4'hF, 32'hAAAA_0002);

    RST = 1'b0;
    idle();
    tick();
    tick();
    chk("reset EMPTY", 32'(empty_v), 32'hF);
    chk("reset STOP", 32'(stop_v), 32'hF);
    chk("reset OUT", OUT, 32'h0);
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
    chk("reset OVERFLOW", 32'(OVERFLOW), 32'h0);
`endif
    RST = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rd, vq[i].rf, vq[i].we, vq[i].wf, vq[i].din, vq[i].im, vq[i].care);
      tick();
      chk($sformatf("row%0d EMPTY", i), 32'(empty_v), 32'(vq[i].e));
      chk($sformatf("row%0d STOP", i), 32'(stop_v), 32'(vq[i].s));
      chk($sformatf("row%0d OUT", i), OUT, vq[i].o);
    end

    // Overflow: channel 1 takes 2..64, then drops 65..299 while unread
    for (int w = 2; w <= 299; w++) begin
      drive(1'b0, 2'd0, 4'b0010, 2'd1, 32'(w), 1'b0, 4'b0000);
      tick();
    end
    chk("ovf full EMPTY", 32'(empty_v), 32'hB);
    chk("ovf full STOP", 32'(stop_v), 32'hB);
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
    chk("ovf flag set", 32'(OVERFLOW), 32'h2);
`endif
    // First read carries a write that must drop (full judged before the read), then 300..317 stream in
    for (int j = 0; j < 83; j++) begin
      drive(j < 81, 2'd1, (j <= 18) ? 4'b0010 : 4'b0000, 2'd1,
            (j == 0) ? 32'h0000_DEAD : 32'(300 + j - 1), 1'b0, 4'b0000);
      tick();
      if (j >= 2) chk($sformatf("ovf OUT%0d", j - 2), OUT, ovf_exp(j - 2));
    end
    chk("ovf drained EMPTY", 32'(empty_v), 32'hF);
    chk("ovf drained STOP", 32'(stop_v), 32'hF);
`ifdef LSAB_CR_OVERFLOW_FLAG_EN
    chk("ovf flag cleared", 32'(OVERFLOW), 32'h0);
`endif

    // Reset mid-stream with words queued on channel 3 and a read in flight
    for (int w = 1; w <= 3; w++) begin
      drive(1'b0, 2'd0, 4'b1000, 2'd3, 32'h3333_0000 + w, 1'b0, 4'b0000);
      tick();
    end
    chk("mid queued EMPTY", 32'(empty_v), 32'hE);
    drive(1'b1, 2'd3, 4'b0000, 2'd0, 32'h0, 1'b0, 4'b0000);
    tick();
    RST = 1'b0;
    idle();
    tick();
    chk("mid reset EMPTY", 32'(empty_v), 32'hF);
    chk("mid reset STOP", 32'(stop_v), 32'hF);
    chk("mid reset OUT", OUT, 32'h0);
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(k < 2, 2'd3, 4'b0000, 2'd0, 32'h0, 1'b0, 4'b0000);
      tick();
      chk($sformatf("post reset EMPTY%0d", k), 32'(empty_v), 32'hF);
      chk($sformatf("post reset OUT%0d", k), OUT, 32'h0);
    end
    drive(1'b0, 2'd0, 4'b1000, 2'd3, 32'h3333_4444, 1'b0, 4'b0000);
    tick();
    chk("fresh write EMPTY", 32'(empty_v), 32'hE);
    drive(1'b1, 2'd3, 4'b0000, 2'd0, 32'h0, 1'b0, 4'b0000);
    tick();
    chk("fresh read EMPTY", 32'(empty_v), 32'hF);
    idle();
    tick();
    chk("fresh OUT lat1", OUT, 32'h0);
    tick();
    chk("fresh OUT lat2", OUT, 32'h3333_4444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
